icache_fetch: RTL and testbench
===============================

ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 The block SHALL be the instruction-cache responder for the fetch-request interface: it accepts fetch_e_/fetch_pc and returns ic_inst/ic_stall.
REQ-002 Parameter ADDR, 32, address width.
REQ-003 Parameter INST, 32, instruction width.
REQ-004 Parameter SETS, 64, number of direct-mapped lines (power of 2).
REQ-005 Parameter LINE_WORDS, 4, instructions per line (power of 2).
REQ-006 Parameter CNT, 32, performance counter width.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset_  in  1  synchronous, active-low reset.
REQ-009 fetch_e_  in  1  fetch request, active low.
REQ-010 fetch_pc  in  ADDR  fetch address, word aligned.
REQ-011 inv_  in  1  invalidate-all request (fence.i), active low.
REQ-012 ic_inst  out  INST  returned instruction.
REQ-013 ic_stall  out  1  response not ready; the requester holds fetch_e_/fetch_pc stable while high.
REQ-014 mem_req_  out  1  line refill request, active low, held until last word returns.
REQ-015 mem_addr  out  ADDR  line-aligned refill address.
REQ-016 mem_valid_  in  1  one refill word valid this cycle, active low.
REQ-017 mem_data  in  INST  refill word, returned in order word 0..LINE_WORDS-1.
REQ-018 hit_cnt, miss_cnt  out  CNT each  performance counters (present only with ICACHE_PERF_EN).

Function
REQ-019 Address split: bits[1:0] byte, then log2(LINE_WORDS) word offset, then log2(SETS) index, remainder tag.
REQ-020 States SHALL be IDLE, REFILL, RESP; reset state IDLE.
REQ-021 IDLE, fetch_e_=0 in cycle N, valid and tag match: ic_inst = addressed word and ic_stall=0 in cycle N+1; one hit accepted per cycle, back-to-back.
REQ-022 IDLE, fetch_e_=0 in cycle N, miss: in N+1 ic_stall=1, mem_req_=0, mem_addr=line-aligned fetch_pc, state REFILL.
REQ-023 REFILL: each mem_valid_=0 cycle writes mem_data to the next word of the indexed line; fetch_e_ ignored; ic_stall stays 1.
REQ-024 On last refill word: mem_req_=1 next cycle, tag written, valid set, state RESP.
REQ-025 RESP (one cycle): ic_inst = requested word, ic_stall=0; next state IDLE, where a new request is accepted that cycle.
REQ-026 mem_valid_ outside REFILL SHALL be ignored.
REQ-027 inv_=0 in IDLE clears all valid bits next cycle; a fetch in the same cycle SHALL be treated as a miss.
REQ-028 inv_=0 during REFILL/RESP is latched; refill and response complete, but the line's valid bit is not set and all valids clear on return to IDLE.
REQ-029 ic_inst holds its last value when no response is produced.

Reset
REQ-030 reset_=0 at a clock edge: state IDLE, all valid bits 0, ic_stall=0, ic_inst=0, mem_req_=1, mem_addr=0, counters 0, pending invalidate cleared.
REQ-031 Reset mid-REFILL SHALL abandon the refill; subsequent stray mem_valid_ pulses are ignored and the line stays invalid.
REQ-032 Tag/data arrays need no reset.

Configuration
REQ-033 Macro ICACHE_PERF_EN defined: hit_cnt increments per hit accepted in IDLE, miss_cnt per refill started; both wrap modulo 2^CNT.
REQ-034 ICACHE_PERF_EN undefined: hit_cnt/miss_cnt ports and logic absent; all other behaviour identical.

Verification (SETS=64, LINE_WORDS=4, refill words 2 cycles after mem_req_, one per cycle)
REQ-035 Cold miss: fetch 0x1004 -> mem_addr=0x1000, mem_req_=0 four cycles, data 0xA0..0xA3, then ic_inst=0xA1, ic_stall=0.
REQ-036 Hits: fetch 0x1000, 0x1008, 0x100C consecutive cycles -> ic_inst 0xA0, 0xA2, 0xA3 on successive cycles, ic_stall=0, mem_req_ stays 1.
REQ-037 Conflict: fetch 0x2004 (same index 0, new tag) -> refill at 0x2000; then fetch 0x1004 -> refill at 0x1000 again.
REQ-038 inv_=0 during 0x3000 refill -> response returned; refetch 0x3000 misses (mem_req_=0).
REQ-039 reset_=0 during refill word 2 -> mem_req_=1, ic_stall=0 next cycle; stray mem_valid_ no effect; fetch 0x1004 misses.
REQ-040 ICACHE_PERF_EN after REQ-035/036 -> hit_cnt=3, miss_cnt=1; undefined build compiles without the ports.

Source files
------------

// File: rtl/icache_fetch_if.sv
// icache_fetch_if: bundles the fetch-request and line-refill signals of the
// instruction cache.
//
//   slave  : the cache (icache_fetch). It receives fetch and refill-data
//            signals and drives the response and refill request.
//   master : the requester/memory side (the core front end plus the refill
//            memory, or a testbench standing in for both).
//
// Signals (all active-low controls end in '_'):
//   fetch_e_   fetch request
//   fetch_pc   fetch address, word aligned
//   inv_       invalidate-all request (fence.i)
//   ic_inst    returned instruction
//   ic_stall   response not ready; requester holds the request while high
//   mem_req_   line refill request, held until the last word returns
//   mem_addr   line-aligned refill address
//   mem_valid_ one refill word valid this cycle
//   mem_data   refill word, delivered in order word 0..LINE_WORDS-1
interface icache_fetch_if #(
    parameter int unsigned ADDR = 32,
    parameter int unsigned INST = 32
);
    logic            fetch_e_;
    logic [ADDR-1:0] fetch_pc;
    logic            inv_;
    logic [INST-1:0] ic_inst;
    logic            ic_stall;
    logic            mem_req_;
    logic [ADDR-1:0] mem_addr;
    logic            mem_valid_;
    logic [INST-1:0] mem_data;

    modport slave (
        input  fetch_e_, fetch_pc, inv_, mem_valid_, mem_data,
        output ic_inst, ic_stall, mem_req_, mem_addr
    );

    modport master (
        output fetch_e_, fetch_pc, inv_, mem_valid_, mem_data,
        input  ic_inst, ic_stall, mem_req_, mem_addr
    );
endinterface

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped instruction cache responder.
//
// A fetch accepted while not refilling returns its instruction one cycle
// later with ic_stall low (hits stream back-to-back). A miss raises ic_stall,
// requests the whole line from memory, fills it word by word, then answers
// in a single response cycle. inv_ clears every valid bit; if it arrives
// while a refill is in flight it is remembered and applied once the response
// has been given, and the refilled line is never marked valid.
//
// Ports:
//   clk       clock, rising edge
//   reset_    synchronous active-low reset
//   bus       icache_fetch_if.slave (fetch request/response + refill)
//   hit_cnt   hits accepted        (only with ICACHE_PERF_EN)
//   miss_cnt  refills started      (only with ICACHE_PERF_EN)
//
// Build option: define ICACHE_PERF_EN to add the hit/miss counters.
module icache_fetch #(
    parameter int unsigned ADDR       = 32,
    parameter int unsigned INST       = 32,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CNT        = 32
) (
    input  logic           clk,
    input  logic           reset_,
`ifdef ICACHE_PERF_EN
    output logic [CNT-1:0] hit_cnt,
    output logic [CNT-1:0] miss_cnt,
`endif
    icache_fetch_if.slave  bus
);

    localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int unsigned TAG_W   = ADDR - TAG_LSB;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRefill, StResp} state_e;

    state_e state_q, state_d;

    // Storage; contents are meaningless until the matching valid bit is set.
    logic [INST-1:0]  data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]  valid_q;

    logic [INST-1:0]  ic_inst_q;
    logic             ic_stall_q;
    logic             mem_req_q;    // active high internally
    logic [ADDR-1:0]  mem_addr_q;   // also holds tag/index of the line in flight
    logic [OFF_W-1:0] req_off_q;    // word the stalled fetch asked for
    logic [OFF_W-1:0] wcnt_q;       // next refill word to write
    logic [INST-1:0]  resp_word_q;  // requested word captured as it streams in
    logic             inv_pend_q;   // invalidate seen while refilling

    // Fetch address decode
    logic [OFF_W-1:0] f_off;
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             tag_hit;
    logic             unused_pc_lsb;

    assign f_off         = bus.fetch_pc[OFF_W+1:2];
    assign f_idx         = bus.fetch_pc[TAG_LSB-1:OFF_W+2];
    assign f_tag         = bus.fetch_pc[ADDR-1:TAG_LSB];
    assign fill_idx      = mem_addr_q[TAG_LSB-1:OFF_W+2];
    assign fill_tag      = mem_addr_q[ADDR-1:TAG_LSB];
    assign tag_hit       = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);
    assign unused_pc_lsb = ^bus.fetch_pc[1:0];

    // Control strobes
    logic accept;     // a new fetch may be taken this cycle (IDLE or RESP)
    logic inv_now;    // valids must be treated as cleared this cycle
    logic hit;
    logic miss;
    logic fill;
    logic fill_last;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // RESP behaves like IDLE for the next request, so a requester that sees
    // ic_stall low may always present its next fetch in that same cycle.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        hit       = 1'b0;
        miss      = 1'b0;
        fill      = 1'b0;
        fill_last = 1'b0;
        inv_now   = !bus.inv_ || inv_pend_q;
        case (state_q)
            StIdle, StResp: begin
                accept  = 1'b1;
                state_d = StIdle;
                if (!bus.fetch_e_) begin
                    if (tag_hit && !inv_now) begin
                        hit = 1'b1;
                    end else begin
                        miss    = 1'b1;
                        state_d = StRefill;
                    end
                end
            end
            StRefill: begin
                if (!bus.mem_valid_) begin
                    fill = 1'b1;
                    if (wcnt_q == LAST_WORD) begin
                        fill_last = 1'b1;
                        state_d   = StResp;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            valid_q     <= '0;
            ic_inst_q   <= '0;
            ic_stall_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            req_off_q   <= '0;
            wcnt_q      <= '0;
            resp_word_q <= '0;
            inv_pend_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (inv_now) begin
                    valid_q <= '0;
                end
                inv_pend_q <= 1'b0;
            end else if (!bus.inv_) begin
                inv_pend_q <= 1'b1;
            end

            if (hit) begin
                ic_inst_q <= data_mem[{f_idx, f_off}];
            end

            if (miss) begin
                ic_stall_q     <= 1'b1;
                mem_req_q      <= 1'b1;
                mem_addr_q     <= {bus.fetch_pc[ADDR-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                req_off_q      <= f_off;
                wcnt_q         <= '0;
                // Line is being overwritten; keep it invalid until the fill completes.
                valid_q[f_idx] <= 1'b0;
            end

            if (fill) begin
                wcnt_q <= wcnt_q + OFF_W'(1);
                if (wcnt_q == req_off_q) begin
                    resp_word_q <= bus.mem_data;
                end
            end

            if (fill_last) begin
                mem_req_q         <= 1'b0;
                ic_stall_q        <= 1'b0;
                ic_inst_q         <= (req_off_q == LAST_WORD) ? bus.mem_data : resp_word_q;
                valid_q[fill_idx] <= !(inv_pend_q || !bus.inv_);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_ && fill) begin
            data_mem[{fill_idx, wcnt_q}] <= bus.mem_data;
        end
        if (reset_ && fill_last) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

    assign bus.ic_inst  = ic_inst_q;
    assign bus.ic_stall = ic_stall_q;
    assign bus.mem_req_ = !mem_req_q;
    assign bus.mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_EN
    logic [CNT-1:0] hit_cnt_q;
    logic [CNT-1:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + CNT'(1);
            end
            if (miss) begin
                miss_cnt_q <= miss_cnt_q + CNT'(1);
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    // Counters not built; width parameter kept for a uniform interface.
    localparam int unsigned unused_cnt_w = CNT;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: self-checking bench for icache_fetch (SETS=64,
// LINE_WORDS=4). The bench plays requester and refill memory. A behavioural
// cache model (valid/tag per set, backing memory as a function of address)
// predicts hit/miss, returned data and counters.
module tb_icache_fetch;

    logic clk = 1'b0;
    logic reset_;
    always #5 clk = ~clk;

    icache_fetch_if #(.ADDR(32), .INST(32)) bus ();

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_fetch #(
        .ADDR(32), .INST(32), .SETS(64), .LINE_WORDS(4), .CNT(32)
    ) dut (
        .clk     (clk),
        .reset_  (reset_),
`ifdef ICACHE_PERF_EN
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt),
`endif
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    bit          mvalid [64];
    logic [21:0] mtag   [64];
    logic [31:0] last_inst;
    int          m_hits;
    int          m_misses;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000100) return 32'hA0 + {30'd0, a[3:2]};
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    task automatic model_clear_all();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear_all();
        last_inst = '0;
        m_hits    = 0;
        m_misses  = 0;
    endtask

    // One fetch; on a miss the bench serves the refill with 'lat' cycles of
    // latency and optionally pulls inv_ low during refill word 'inv_cyc'.
    task automatic do_fetch(input logic [31:0] pc, input bit inv_now, input int inv_cyc,
                            input int lat, input string name);
        int          idx;
        logic [21:0] tag;
        logic [31:0] line;
        bit          exp_miss;
        bit          pend;
        idx  = int'(pc[9:4]);
        tag  = pc[31:10];
        line = {pc[31:4], 4'b0};
        pend = 1'b0;
        bus.fetch_e_ = 1'b0;
        bus.fetch_pc = pc;
        bus.inv_     = !inv_now;
        if (inv_now) model_clear_all();
        exp_miss = !(mvalid[idx] && mtag[idx] == tag);
        @(negedge clk);
        bus.inv_ = 1'b1;
        checks++;
        if (bus.ic_stall !== exp_miss) begin
            errors++;
            $display("FAIL %s stall pc=%h: got %b expected %b", name, pc, bus.ic_stall, exp_miss);
        end
        if (!exp_miss) begin
            m_hits++;
            last_inst = mem_word(pc);
            checks++;
            if (bus.ic_inst !== last_inst) begin
                errors++;
                $display("FAIL %s hit data pc=%h: got %h expected %h", name, pc, bus.ic_inst,
                         last_inst);
            end
            checks++;
            if (bus.mem_req_ !== 1'b1) begin
                errors++;
                $display("FAIL %s hit mem_req_: got %b expected 1", name, bus.mem_req_);
            end
        end else begin
            m_misses++;
            checks++;
            if (bus.mem_req_ !== 1'b0 || bus.mem_addr !== line) begin
                errors++;
                $display("FAIL %s refill req pc=%h: got req_=%b addr=%h expected req_=0 addr=%h",
                         name, pc, bus.mem_req_, bus.mem_addr, line);
            end
            for (int k = 1; k < lat; k++) @(negedge clk);
            if (lat > 0) @(negedge clk);
            for (int w = 0; w < 4; w++) begin
                bus.mem_valid_ = 1'b0;
                bus.mem_data   = mem_word(line + 32'(4 * w));
                if (w == inv_cyc) begin
                    bus.inv_ = 1'b0;
                    pend     = 1'b1;
                end
                @(negedge clk);
                bus.inv_       = 1'b1;
                bus.mem_valid_ = 1'b1;
                bus.mem_data   = $urandom;
                if (w < 3) begin
                    checks++;
                    if (bus.ic_stall !== 1'b1 || bus.mem_req_ !== 1'b0) begin
                        errors++;
                        $display("FAIL %s refill word %0d: got stall=%b req_=%b expected 1/0",
                                 name, w, bus.ic_stall, bus.mem_req_);
                    end
                end
            end
            last_inst = mem_word(pc);
            checks++;
            if (bus.ic_stall !== 1'b0 || bus.mem_req_ !== 1'b1 || bus.ic_inst !== last_inst) begin
                errors++;
                $display("FAIL %s response pc=%h: got stall=%b req_=%b inst=%h expected 0/1/%h",
                         name, pc, bus.ic_stall, bus.mem_req_, bus.ic_inst, last_inst);
            end
            if (pend) begin
                model_clear_all();
            end else begin
                mvalid[idx] = 1'b1;
                mtag[idx]   = tag;
            end
        end
        bus.fetch_e_ = 1'b1;
    endtask

    task automatic do_inv(input string name);
        bus.fetch_e_ = 1'b1;
        bus.inv_     = 1'b0;
        @(negedge clk);
        bus.inv_ = 1'b1;
        model_clear_all();
        checks++;
        if (bus.ic_stall !== 1'b0 || bus.ic_inst !== last_inst) begin
            errors++;
            $display("FAIL %s inv idle: got stall=%b inst=%h expected 0/%h", name,
                     bus.ic_stall, bus.ic_inst, last_inst);
        end
    endtask

    // Idle cycles, optionally with stray refill strobes that must be ignored.
    task automatic do_idle(input int n, input bit stray, input string name);
        for (int i = 0; i < n; i++) begin
            bus.fetch_e_   = 1'b1;
            bus.mem_valid_ = stray ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.mem_data   = $urandom;
            @(negedge clk);
            checks++;
            if (bus.ic_stall !== 1'b0 || bus.ic_inst !== last_inst || bus.mem_req_ !== 1'b1) begin
                errors++;
                $display("FAIL %s idle hold: got stall=%b inst=%h req_=%b expected 0/%h/1",
                         name, bus.ic_stall, bus.ic_inst, bus.mem_req_, last_inst);
            end
        end
        bus.mem_valid_ = 1'b1;
    endtask

    task automatic test_reset();
        reset_         = 1'b0;
        bus.fetch_e_   = 1'b1;
        bus.inv_       = 1'b1;
        bus.mem_valid_ = 1'b1;
        bus.fetch_pc   = '0;
        bus.mem_data   = '0;
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        model_reset();
        checks++;
        if (bus.ic_stall !== 1'b0 || bus.ic_inst !== 32'd0 || bus.mem_req_ !== 1'b1 ||
            bus.mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset outputs: got stall=%b inst=%h req_=%b addr=%h expected 0/0/1/0",
                     bus.ic_stall, bus.ic_inst, bus.mem_req_, bus.mem_addr);
        end
`ifdef ICACHE_PERF_EN
        checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset counters: got hit=%0d miss=%0d expected 0/0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_cold_miss();
        do_fetch(32'h1004, 1'b0, -1, 2, "cold_miss");
    endtask

    task automatic test_back_to_back_hits();
        do_fetch(32'h1000, 1'b0, -1, 2, "hit0");
        do_fetch(32'h1008, 1'b0, -1, 2, "hit2");
        do_fetch(32'h100C, 1'b0, -1, 2, "hit3");
        do_idle(2, 1'b1, "after_hits");
    endtask

    task automatic test_perf_counters(input string name);
`ifdef ICACHE_PERF_EN
        checks++;
        if (hit_cnt !== 32'(m_hits) || miss_cnt !== 32'(m_misses)) begin
            errors++;
            $display("FAIL %s counters: got hit=%0d miss=%0d expected %0d/%0d", name,
                     hit_cnt, miss_cnt, m_hits, m_misses);
        end
`else
        $display("perf counters not built (%s)", name);
`endif
    endtask

    task automatic test_conflict();
        do_fetch(32'h2004, 1'b0, -1, 2, "conflict_new");
        do_fetch(32'h1004, 1'b0, -1, 2, "conflict_old");
        do_fetch(32'h1004, 1'b0, -1, 2, "conflict_rehit");
    endtask

    task automatic test_invalidate();
        do_fetch(32'h3000, 1'b0, 1, 2, "inv_refill");
        do_fetch(32'h3000, 1'b0, -1, 2, "inv_refetch");
        do_fetch(32'h3000, 1'b0, -1, 2, "inv_rehit");
        do_fetch(32'h3008, 1'b1, -1, 2, "inv_with_fetch");
        do_inv("inv_idle");
        do_fetch(32'h3008, 1'b0, -1, 1, "inv_idle_refetch");
    endtask

    task automatic test_reset_mid_refill();
        do_inv("pre_reset");
        bus.fetch_e_ = 1'b0;
        bus.fetch_pc = 32'h1004;
        @(negedge clk);
        checks++;
        if (bus.ic_stall !== 1'b1 || bus.mem_req_ !== 1'b0) begin
            errors++;
            $display("FAIL rst_refill start: got stall=%b req_=%b expected 1/0",
                     bus.ic_stall, bus.mem_req_);
        end
        repeat (2) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            bus.mem_valid_ = 1'b0;
            bus.mem_data   = mem_word(32'h1000 + 32'(4 * w));
            if (w == 2) reset_ = 1'b0;
            @(negedge clk);
        end
        reset_       = 1'b1;
        bus.fetch_e_ = 1'b1;
        model_reset();
        checks++;
        if (bus.mem_req_ !== 1'b1 || bus.ic_stall !== 1'b0 || bus.ic_inst !== 32'd0) begin
            errors++;
            $display("FAIL rst_refill abandon: got req_=%b stall=%b inst=%h expected 1/0/0",
                     bus.mem_req_, bus.ic_stall, bus.ic_inst);
        end
        for (int i = 0; i < 2; i++) begin
            bus.mem_valid_ = 1'b0;
            bus.mem_data   = mem_word(32'h100C);
            @(negedge clk);
            checks++;
            if (bus.mem_req_ !== 1'b1 || bus.ic_stall !== 1'b0) begin
                errors++;
                $display("FAIL rst_refill stray %0d: got req_=%b stall=%b expected 1/0", i,
                         bus.mem_req_, bus.ic_stall);
            end
        end
        bus.mem_valid_ = 1'b1;
        do_fetch(32'h1004, 1'b0, -1, 2, "rst_refill_refetch");
        test_perf_counters("after_reset_refill");
    endtask

    task automatic test_random();
        for (int it = 0; it < 250; it++) begin
            int          r;
            int          lat;
            int          icyc;
            logic [31:0] pc;
            r    = int'($urandom_range(0, 99));
            lat  = int'($urandom_range(1, 3));
            icyc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            pc   = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                   (32'($urandom_range(0, 3)) << 2);
            if (r < 70)      do_fetch(pc, 1'b0, icyc, lat, "rand_fetch");
            else if (r < 78) do_fetch(pc, 1'b1, -1, lat, "rand_inv_fetch");
            else if (r < 86) do_inv("rand_inv");
            else             do_idle(int'($urandom_range(1, 3)), 1'b1, "rand_idle");
        end
        test_perf_counters("random");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ = 1'b0;
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_back_to_back_hits();
        test_perf_counters("cold_plus_hits");
`ifdef ICACHE_PERF_EN
        checks++;
        if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin
            errors++;
            $display("FAIL perf after hits: got hit=%0d miss=%0d expected 3/1", hit_cnt, miss_cnt);
        end
`endif
        test_conflict();
        test_invalidate();
        test_reset_mid_refill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
